// File: rtl/factorial_pkg.sv
// Shared constants for the factorial slave/core pair: state codes, widths, overflow limit.
package factorial_pkg;
    localparam int N_W           = 32;
    localparam int R_W           = 64;
    localparam int OVF_LIMIT_DEF = 20;

    localparam logic [3:0] ST_IDLE  = 4'h0;
    localparam logic [3:0] ST_DONE  = 4'h1;
    localparam logic [3:0] ST_CHECK = 4'h2;
    localparam logic [3:0] ST_MUL   = 4'h4;

    typedef enum logic [3:0] {
        S_IDLE  = ST_IDLE,
        S_DONE  = ST_DONE,
        S_CHECK = ST_CHECK,
        S_MUL   = ST_MUL
    } fsm_e;
endpackage

// File: rtl/factorial_shift_mul.sv
// Serial 64x32 shift-add multiplier, one multiplier bit per cycle, product mod 2^64.
module factorial_shift_mul
    import factorial_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load,
    input  logic [R_W-1:0] mcand_in,
    input  logic [N_W-1:0] mplier_in,
    output logic           busy,
    output logic           done,
    output logic [R_W-1:0] product
);
    logic [R_W-1:0] acc, mcand;
    logic [N_W-1:0] mplier;

    // product is the accumulator after adding the current bit, so the consumer
    // can capture it on the same edge that consumes the last bit
    assign product = mplier[0] ? acc + mcand : acc;
    assign done    = (mplier[N_W-1:1] == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            busy   <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= mcand_in;
            mplier <= mplier_in;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/factorial_core.sv
// Iterative N! engine driven by the bus slave's start/clear level registers.
module factorial_core
    import factorial_pkg::*;
#(
    parameter int OVF_LIMIT = OVF_LIMIT_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N_W-1:0] N_value,
    input  logic           op_start,
    input  logic           op_clear,
    output logic [R_W-1:0] result,
    output logic [3:0]     state,
    output logic           overflow
);
    fsm_e           state_q, state_d;
    logic [N_W-1:0] k_q, k_d;
    logic [R_W-1:0] result_d;
    logic           ovf_d;
    logic           op_start_d;
    logic           start_evt;
    logic           mul_load, mul_busy, mul_done;
    logic [R_W-1:0] mul_product;

    assign start_evt = op_start & ~op_start_d;
    assign state     = state_q;

    factorial_shift_mul u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (mul_load),
        .mcand_in  (result),
        .mplier_in (k_q),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            result     <= '0;
            overflow   <= 1'b0;
            op_start_d <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            result     <= result_d;
            overflow   <= ovf_d;
            op_start_d <= op_start;
        end
    end

    // clear wins over everything, including a coincident start edge
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        result_d = result;
        ovf_d    = overflow;
        mul_load = 1'b0;
        if (op_clear) begin
            state_d  = S_IDLE;
            result_d = '0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_evt) begin
                        k_d      = N_value;
                        result_d = R_W'(1);
                        ovf_d    = (N_value > N_W'(OVF_LIMIT));
                        state_d  = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (k_q <= N_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        mul_load = 1'b1;
                        state_d  = S_MUL;
                    end
                end
                S_MUL: begin
                    if (mul_busy && mul_done) begin
                        result_d = mul_product;
                        k_d      = k_q - N_W'(1);
                        state_d  = S_CHECK;
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_factorial_core.sv
// Scoreboard bench for factorial_core: randomized and directed runs against a plain N! model.
module tb_factorial_core;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] N_value = '0;
    logic        op_start = 1'b0;
    logic        op_clear = 1'b0;
    logic [63:0] result;
    logic [3:0]  state;
    logic        overflow;

    factorial_core dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .N_value  (N_value),
        .op_start (op_start),
        .op_clear (op_clear),
        .result   (result),
        .state    (state),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [63:0] res;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] fact(input int n);
        logic [63:0] p = 64'd1;
        for (int i = 2; i <= n; i++) p = p * 64'(i);
        return p;
    endfunction

    // edges from the start-sampling edge until DONE is visible
    function automatic int latency(input int n);
        int t = 2;
        for (int i = 2; i <= n; i++) t += 1 + $clog2(i + 1);
        return t;
    endfunction

    // monitor: pop one expectation each time the DUT enters DONE
    initial begin
        logic [3:0] prev = 4'h0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && !(state inside {4'h0, 4'h1, 4'h2, 4'h4}))
                chk("state_encoding", 64'(state), 64'h0);
            if (state == 4'h1 && prev != 4'h1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("result_n%0d", e.n), result, e.res);
                    chk($sformatf("overflow_n%0d", e.n), 64'(overflow), 64'(e.ovf));
                    chk($sformatf("latency_n%0d", e.n), 64'(cyc), 64'(e.done_cyc));
                end
            end
            prev = state;
        end
    end

    task automatic start_run(input int n, input bit push);
        exp_t e;
        @(negedge clk);
        op_start = 1'b0;
        @(negedge clk);
        N_value  = 32'(n);
        op_start = 1'b1;
        if (push) begin
            e.n        = n;
            e.res      = fact(n);
            e.ovf      = (n > 20);
            e.done_cyc = cyc + latency(n);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input string name);
        int k = 0;
        while (state != s && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (state != s) chk({name, "_timeout"}, 64'(state), 64'(s));
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        op_clear = 1'b1;
        op_start = 1'b0;
        @(negedge clk);
        op_clear = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_state", 64'(state), 64'h0);
        chk("reset_result", result, 64'h0);
        chk("reset_overflow", 64'(overflow), 64'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // N=5 with state walk, then op_start held high must not restart
        start_run(5, 1'b1);
        @(negedge clk);
        chk("n5_first_state", 64'(state), 64'h2);
        @(negedge clk);
        chk("n5_second_state", 64'(state), 64'h4);
        wait_state(4'h1, "n5");
        repeat (5) @(negedge clk);
        chk("n5_hold_state", 64'(state), 64'h1);
        chk("n5_hold_result", result, 64'd120);

        pulse_clear();
        chk("clear_state", 64'(state), 64'h0);
        chk("clear_result", result, 64'h0);
        start_run(0, 1'b1);
        wait_state(4'h1, "n0");
        pulse_clear();
        start_run(1, 1'b1);
        wait_state(4'h1, "n1");

        pulse_clear();
        start_run(20, 1'b1);
        wait_state(4'h1, "n20");
        chk("n20_const", result, 64'h21C3_677C_82B4_0000);
        pulse_clear();
        start_run(21, 1'b1);
        wait_state(4'h1, "n21");
        chk("n21_const", result, 64'hC507_7D36_B8C4_0000);
        chk("n21_ovf", 64'(overflow), 64'd1);

        // clear mid-multiply aborts
        pulse_clear();
        start_run(10, 1'b0);
        wait_state(4'h4, "n10_mul");
        @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        chk("abort_state", 64'(state), 64'h0);
        chk("abort_result", result, 64'h0);
        start_run(10, 1'b1);
        wait_state(4'h1, "n10");
        chk("n10_const", result, 64'h375F00);

        // start edges in DONE are ignored
        repeat (2) begin
            @(negedge clk) op_start = 1'b0;
            @(negedge clk) op_start = 1'b1;
        end
        @(negedge clk);
        chk("done_toggle_state", 64'(state), 64'h1);
        chk("done_toggle_result", result, 64'h375F00);

        // coincident clear and start edge: start is lost
        @(negedge clk) op_start = 1'b0;
        @(negedge clk) begin op_clear = 1'b1; op_start = 1'b1; end
        @(negedge clk) op_clear = 1'b0;
        chk("clr_start_state", 64'(state), 64'h0);
        repeat (3) @(negedge clk);
        chk("clr_start_idle", 64'(state), 64'h0);
        chk("clr_start_result", result, 64'h0);

        // async reset mid-multiply
        start_run(12, 1'b0);
        wait_state(4'h4, "n12_mul");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("areset_state", 64'(state), 64'h0);
        chk("areset_result", result, 64'h0);
        chk("areset_ovf", 64'(overflow), 64'h0);
        @(negedge clk);
        reset_n  = 1'b1;
        op_start = 1'b0;
        start_run(4, 1'b1);
        wait_state(4'h1, "n4");
        chk("n4_const", result, 64'd24);

        for (int i = 0; i < 15; i++) begin
            pulse_clear();
            start_run(int'($urandom_range(0, 25)), 1'b1);
            wait_state(4'h1, "rand");
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/factorial_core.md
Name: factorial_core

Overview:
- Compute engine that sits directly downstream of the factorial bus slave.
- Consumes the slave's N_value, op_start and op_clear registers; computes N! using an iterative shift-add multiplier.
- Returns a 64-bit result and a 4-bit state code to the slave. state[0] is the slave's done/interrupt qualifier.

Parameters:
- OVF_LIMIT, 20, largest N whose factorial fits in 64 bits; N_value > OVF_LIMIT sets overflow.
- N_W, 32, width of N_value and of the multiplier operand (fixed by the slave interface).
- R_W, 64, width of result (fixed by the slave interface).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- N_value  in  32  operand N, sampled on the start edge only.
- op_start  in  1  level register from slave; a rising edge starts a computation.
- op_clear  in  1  level register from slave; while high, forces IDLE and clears outputs.
- result  out  64  running/final product, N! mod 2^64.
- state  out  4  ST_IDLE=4'h0, ST_DONE=4'h1, ST_CHECK=4'h2, ST_MUL=4'h4.
- overflow  out  1  high when the latched N exceeded OVF_LIMIT; result is then truncated.

Behaviour:
- Reset (async, reset_n=0): state=ST_IDLE, result=0, overflow=0; internal k, acc, mcand, mplier=0; op_start_d=0.
- op_start_d <= op_start every cycle in every state. start_evt = op_start & ~op_start_d.
- op_clear=1, any state: next state ST_IDLE, result=0, overflow=0.
  - op_clear has priority over start_evt; a start edge coinciding with clear is lost.
  - Clear mid-computation aborts it.
- ST_IDLE: on start_evt: k<=N_value, result<=1, overflow<=(N_value>OVF_LIMIT), go ST_CHECK. Otherwise hold outputs.
- ST_CHECK: if k<=1, go ST_DONE. Else acc<=0, mcand<=result, mplier<=k, go ST_MUL.
- ST_MUL, one multiplier bit per cycle:
  - if mplier[0]: acc_nxt = acc + mcand (mod 2^64).
  - mcand <<= 1 (bits above 63 discarded); mplier >>= 1.
  - When mplier[31:1]==0 (last bit consumed): result<=acc_nxt, k<=k-1, go ST_CHECK.
  - Each ST_MUL visit lasts bitlen(k) cycles (position of the MSB + 1).
- ST_DONE: hold result, overflow and state. start_evt is ignored; only op_clear leaves ST_DONE.
- start_evt in ST_CHECK or ST_MUL is ignored.
- result shows the partial product after each multiply completes; it is final only in ST_DONE.
- Latency: T = number of clock edges, including the start-sampling edge, until state==ST_DONE.
  - T = 2 + Σ_{k=2..N}(1+bitlen(k)).
  - N=0 or N=1: T=2. N=3: T=8. N=5: T=16.
- Boundaries:
  - N=0 gives result=1.
  - N=20 gives 64'h21C3_677C_82B4_0000 with overflow=0.
  - N≥21 still runs to completion, giving the product mod 2^64 with overflow=1.
  - A large N runs indefinitely long; op_clear is the only abort.
- state only ever holds the four encodings above. state[0]=1 iff ST_DONE.

Decomposition:
- Package factorial_pkg holds:
  - state constants ST_IDLE, ST_DONE, ST_CHECK, ST_MUL (4-bit);
  - default OVF_LIMIT;
  - N_W and R_W.
- The slave module is also to import the state constants from factorial_pkg.
- One sub-module, factorial_shift_mul: 64x32 serial shift-add multiplier.
  - Ports: load, operands, busy, done, product.
  - The FSM (IDLE/CHECK/DONE, k counter, clear/start handling) stays in factorial_core.

Test Plan:
- Reset mid-ST_MUL (reset_n low 1 cycle): state=0, result=0 and overflow=0 immediately, asynchronously; a subsequent op_start rise with N=4 gives result=24.
- N=5, op_start 0→1: state 2,4,... reaches 4'h1 exactly 16 edges after the start edge; result=120, overflow=0. op_start held high then causes no restart.
- N=0 and N=1 (separate runs, op_clear between): ST_DONE after 2 edges, result=1 each time.
- N=20: result=64'h21C3_677C_82B4_0000, overflow=0. N=21: result=64'hC507_7D36_B8C4_0000 (21! mod 2^64), overflow=1.
- N=10, op_clear pulsed 1 cycle mid-ST_MUL: next state 4'h0, result=0. A new rising op_start with N=10 gives result=3628800 (0x375F00).
- In ST_DONE, toggle op_start 0→1→0→1 without op_clear: state stays 4'h1, result unchanged. op_clear and op_start rising in the same cycle: state→IDLE, no computation starts.
